// File: rtl/gate_pkg.sv
// Shared types and helpers for the gated register bank: channel state encoding,
// idle-counter sizing and the saturating add used by the gated-cycle statistics.
package gate_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_GATED  = 2'd1,
    ST_WAKE   = 2'd2
  } state_e;

  // Bits needed to count 0..n; never less than one bit.
  function automatic int idle_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // a + b clamped to 2^w-1; w may be at most 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/gate_channel.sv
// One channel of the bank: data register, idle counter and the ACTIVE/GATED/WAKE
// controller that requests clock gating and replays the first post-gate load.
module gate_channel
  import gate_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned IDLE_CNT = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  input  logic         force_on_i,
  output logic [W-1:0] q_o,
  output logic         gate_req_o
);

  localparam int IW = idle_w(IDLE_CNT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CNT - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [W-1:0]  pend_q, pend_d;
  logic [W-1:0]  data_q, data_d;
  logic          gate_q, gate_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      pend_q  <= '0;
      data_q  <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      gate_q  <= gate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    pend_d  = pend_q;
    data_d  = data_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (en_i) begin
          data_d = d_i;
          idle_d = '0;
        end else if (force_on_i) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_GATED;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_GATED: begin
        // The data clock is stopped here, so capture into the free-running pending reg.
        if (en_i) begin
          pend_d  = d_i;
          state_d = ST_WAKE;
        end else if (force_on_i) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_WAKE: begin
        data_d  = en_i ? d_i : pend_q;
        idle_d  = '0;
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d = ST_ACTIVE;
        idle_d  = '0;
      end
    endcase
    gate_d = (state_d == ST_GATED);
  end

  assign q_o        = data_q;
  assign gate_req_o = gate_q;

endmodule

// File: rtl/gated_reg_bank.sv
// Multi-channel enabled register bank with per-channel clock-gate requests and a
// saturating count of gated channel-cycles.
module gated_reg_bank
  import gate_pkg::*;
#(
  parameter int unsigned NCH      = 5,
  parameter int unsigned W        = 8,
  parameter int unsigned IDLE_CNT = 4,
  parameter int unsigned SW       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NCH-1:0]   EN,
  input  logic [NCH*W-1:0] D_IN,
  input  logic             FORCE_ON,
  output logic [NCH*W-1:0] OUT,
  output logic [NCH-1:0]   GATE_REQ,
  output logic [SW-1:0]    GATED_CNT
);

  localparam int PW = $clog2(NCH + 1);

  logic [PW-1:0] pop;
  logic [SW-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gate_channel #(
      .W        (W),
      .IDLE_CNT (IDLE_CNT)
    ) u_ch (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .en_i       (EN[i]),
      .d_i        (D_IN[i*W +: W]),
      .force_on_i (FORCE_ON),
      .q_o        (OUT[i*W +: W]),
      .gate_req_o (GATE_REQ[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) pop = pop + PW'(GATE_REQ[i]);
  end

  assign cnt_d = SW'(sat_add(32'(cnt_q), 32'(pop), SW));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign GATED_CNT = cnt_q;

endmodule
